// File: rtl/core_launch_ctrl_if.sv
// Host-side bundle for the core launch sequencer: launch request,
// per-core handshakes and the status outputs shown on the GPIO LEDs.
interface core_launch_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 16
);
    logic                 go;
    logic [NUM_CORES-1:0] core_en;
    logic [NUM_CORES-1:0] core_done;
    logic                 ack;
    logic [NUM_CORES-1:0] core_start;
    logic [1:0]           phase;
    logic [NUM_CORES-1:0] done_mask;
    logic                 all_done;
    logic                 timeout;
    logic [CNT_W-1:0]     cycle_count;

    modport master (
        output go, core_en, core_done, ack,
        input  core_start, phase, done_mask,
        input  all_done, timeout, cycle_count
    );

    modport slave (
        input  go, core_en, core_done, ack,
        output core_start, phase, done_mask,
        output all_done, timeout, cycle_count
    );
endinterface

// File: rtl/core_launch_ctrl.sv
// Launches enabled ML cores, gathers their done pulses and
// reports completion or timeout on the 2-bit LED phase code.
module core_launch_ctrl #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input logic               clk,
    input logic               rst,
    core_launch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nxt;
    logic [NUM_CORES-1:0] en_q, en_nxt;
    logic [NUM_CORES-1:0] mask_nxt, start_nxt, hit;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 to_nxt, ad_nxt;
    logic                 complete, expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion looks at this cycle's pulses, not just the stored mask.
    assign hit      = bus.done_mask | (bus.core_done & en_q);
    assign complete = (hit == en_q);
    assign expire   = (bus.cycle_count == TO_LAST);

    always_comb begin
        state_nxt = state;
        en_nxt    = en_q;
        mask_nxt  = bus.done_mask;
        cnt_nxt   = bus.cycle_count;
        to_nxt    = bus.timeout;
        start_nxt = '0;
        ad_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.go && (|bus.core_en)) begin
                    state_nxt = START;
                    en_nxt    = bus.core_en;
                    mask_nxt  = '0;
                    cnt_nxt   = '0;
                    to_nxt    = 1'b0;
                    start_nxt = bus.core_en;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                mask_nxt = hit;
                if (!(&bus.cycle_count)) begin
                    cnt_nxt = bus.cycle_count + CNT_W'(1);
                end
                if (complete) begin
                    state_nxt = DONE;
                    ad_nxt    = 1'b1;
                end else if (expire) begin
                    state_nxt = DONE;
                    to_nxt    = 1'b1;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q            <= '0;
            bus.core_start  <= '0;
            bus.done_mask   <= '0;
            bus.all_done    <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.cycle_count <= '0;
        end else begin
            en_q            <= en_nxt;
            bus.core_start  <= start_nxt;
            bus.done_mask   <= mask_nxt;
            bus.all_done    <= ad_nxt;
            bus.timeout     <= to_nxt;
            bus.cycle_count <= cnt_nxt;
        end
    end

    assign bus.phase = state;
endmodule

// File: tb/tb_core_launch_ctrl.sv
// Scoreboard bench for core_launch_ctrl: each launch pushes its
// expected outcome, popped when the DUT first reports DONE.
module tb_core_launch_ctrl;
    localparam int NC  = 4;
    localparam int TO  = 8;
    localparam int CW  = 16;

    typedef logic [3:0] dv_t [12];
    typedef struct {
        logic [3:0]  mask;
        logic        to;
        logic        ad;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   st_cnt;
    int   ad_cnt;
    exp_t sb[$];
    logic [1:0] prev_phase;

    core_launch_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

    core_launch_ctrl #(
        .NUM_CORES(NC),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [3:0] en, input dv_t dv);
        exp_t e;
        logic [3:0] m;
        m = 4'h0;
        for (int k = 0; k < TO; k++) begin
            m = m | (dv[k] & en);
            if (m == en) begin
                e.mask = m; e.to = 1'b0; e.ad = 1'b1;
                e.cnt = 16'(k + 1);
                return e;
            end
        end
        e.mask = m; e.to = 1'b1; e.ad = 1'b0; e.cnt = 16'(TO);
        return e;
    endfunction

    // Output monitor: pops the scoreboard on the first DONE cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_phase = 2'b00;
        end else begin
            if (bus.all_done) ad_cnt++;
            if (|bus.core_start) st_cnt++;
            if (bus.phase == 2'b11 && prev_phase != 2'b11) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_mask", bus.done_mask, e.mask);
                    chk("res_alldone", bus.all_done, e.ad);
                    chk("res_timeout", bus.timeout, e.to);
                    chk("res_count", bus.cycle_count, e.cnt);
                end
            end
            prev_phase = bus.phase;
        end
    end

    task automatic do_run(input logic [3:0] en, input dv_t dv,
                          input logic [3:0] noise);
        exp_t e;
        logic [3:0] rm;
        int k;
        st_cnt = 0;
        ad_cnt = 0;
        e = model(en, dv);
        bus.go = 1'b1;
        bus.core_en = en;
        sb.push_back(e);
        @(negedge clk);
        bus.go = 1'b0;
        bus.core_done = noise;
        chk("start_phase", bus.phase, 2'b01);
        chk("start_vec", bus.core_start, en);
        chk("clr_mask", bus.done_mask, 4'h0);
        chk("clr_count", bus.cycle_count, 16'd0);
        chk("clr_timeout", bus.timeout, 1'b0);
        @(negedge clk);
        bus.core_done = 4'h0;
        chk("wait_phase", bus.phase, 2'b10);
        chk("wait_nostart", bus.core_start, 4'h0);
        chk("start_ignored", bus.done_mask, 4'h0);
        rm = 4'h0;
        k = 0;
        while (bus.phase == 2'b10 && k < 20) begin
            bus.core_done = (k < 12) ? dv[k] : 4'h0;
            @(negedge clk);
            rm = rm | (bus.core_done & en);
            bus.core_done = 4'h0;
            k++;
            chk("mask_run", bus.done_mask, rm);
            chk("count_run", bus.cycle_count, 32'(k));
        end
        chk("done_phase", bus.phase, 2'b11);
        bus.go = 1'b1;
        bus.core_done = 4'hF;
        repeat (2) @(negedge clk);
        bus.go = 1'b0;
        bus.core_done = 4'h0;
        chk("hold_phase", bus.phase, 2'b11);
        chk("hold_mask", bus.done_mask, e.mask);
        chk("hold_count", bus.cycle_count, e.cnt);
        chk("hold_timeout", bus.timeout, e.to);
        chk("start_once", st_cnt, 1);
        chk("alldone_cnt", ad_cnt, e.ad ? 1 : 0);
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("ack_idle", bus.phase, 2'b00);
        chk("ack_nostart", bus.core_start, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dv_t v;
        n_vec = 0;
        n_bad = 0;
        st_cnt = 0;
        ad_cnt = 0;
        prev_phase = 2'b00;
        rst = 1'b1;
        bus.go = 1'b0;
        bus.core_en = 4'h0;
        bus.core_done = 4'h0;
        bus.ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_phase", bus.phase, 2'b00);
        chk("rst_start", bus.core_start, 4'h0);
        chk("rst_mask", bus.done_mask, 4'h0);
        chk("rst_alldone", bus.all_done, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        chk("rst_count", bus.cycle_count, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        v = '{default: 4'h0};
        v[0] = 4'h1; v[1] = 4'h2; v[2] = 4'h4; v[3] = 4'h8;
        do_run(4'hF, v, 4'h0);
        do_ack();

        v = '{default: 4'h0};
        v[0] = 4'hA; v[1] = 4'h5;
        do_run(4'h5, v, 4'h5);
        do_ack();

        v = '{default: 4'h0};
        v[0] = 4'h1;
        do_run(4'h3, v, 4'h0);
        do_ack();

        v = '{default: 4'h0};
        v[0] = 4'h1; v[7] = 4'h2;
        do_run(4'h3, v, 4'h0);
        do_ack();

        bus.go = 1'b1;
        bus.core_en = 4'h0;
        repeat (2) begin
            @(negedge clk);
            chk("zero_en_phase", bus.phase, 2'b00);
            chk("zero_en_start", bus.core_start, 4'h0);
        end
        bus.go = 1'b0;
        chk("idle_keep_mask", bus.done_mask, 4'h3);
        chk("idle_keep_count", bus.cycle_count, 16'd8);

        v = '{default: 4'h0};
        v[0] = 4'hF;
        do_run(4'hC, v, 4'h0);
        bus.ack = 1'b1;
        bus.go = 1'b1;
        bus.core_en = 4'hF;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("ackgo_phase", bus.phase, 2'b00);
        chk("ackgo_start", bus.core_start, 4'h0);
        v = '{default: 4'h0};
        v[0] = 4'h3; v[1] = 4'hC;
        do_run(4'hF, v, 4'h0);
        do_ack();

        ad_cnt = 0;
        bus.go = 1'b1;
        bus.core_en = 4'hF;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        bus.core_done = 4'h1;
        @(negedge clk);
        bus.core_done = 4'h2;
        @(negedge clk);
        bus.core_done = 4'h0;
        chk("pre_rst_mask", bus.done_mask, 4'h3);
        chk("pre_rst_phase", bus.phase, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", bus.phase, 2'b00);
        chk("arst_start", bus.core_start, 4'h0);
        chk("arst_mask", bus.done_mask, 4'h0);
        chk("arst_alldone", bus.all_done, 1'b0);
        chk("arst_timeout", bus.timeout, 1'b0);
        chk("arst_count", bus.cycle_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_phase", bus.phase, 2'b00);
        chk("post_rst_alldone", ad_cnt, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
